alu_result_display: RTL and testbench
=====================================

// Module: alu_result_display
// PURPOSE
//  Downstream consumer of the 6-bit ALU. Samples X, OVF and fxn, converts signed X to sign + 2 BCD digits
//  with a sequential double-dabble FSM, and time-multiplexes the Basys 3 4-digit 7-segment display.
//  The OVF flags drive two LEDs, and both digits and LEDs are updated from the same snapshot.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles each digit is lit (1 kHz/digit at 100 MHz); legal range 2..2^20
// PORTS
//  clk      in   1  system clock; all logic is on its rising edge
//  rst      in   1  synchronous reset, active-high
//  X        in   6  ALU result, two's complement
//  OVF      in   2  ALU flags {c_out, overflow}
//  fxn      in   3  ALU function select; shown as a digit
//  hold     in   1  1 = freeze the display (no new conversion starts)
//  seg      out  7  cathodes, active-low, {g,f,e,d,c,b,a}
//  dp       out  1  decimal point, active-low; held 1 (off)
//  an       out  4  anodes, active-low; an[0] is the rightmost digit
//  led_ovf  out  2  registered copy of OVF from the displayed snapshot
//  busy     out  1  1 while a conversion is in flight
// BEHAVIOUR
//  Reset:
//  - seg=7'h7F, an=4'hF, dp=1, led_ovf=0, busy=0, FSM=IDLE.
//  - Display regs are blank, refresh counter=0, digit index=0.
//  - A valid flag is cleared, which forces one conversion after reset.
//  - rst applies on any edge, including mid-conversion; an in-flight result is discarded.
//  Sampling: x_q/ovf_q/fxn_q register X/OVF/fxn on every edge. Call this edge E0.
//  FSM states IDLE -> LOAD -> SHIFT(x6) -> DONE -> IDLE:
//  - IDLE: if hold=0 and ({x_q,ovf_q,fxn_q} != last, or valid=0), go to LOAD at E1. Otherwise stay.
//  - LOAD: snapshot x_q/ovf_q/fxn_q; sign=x_q[5]; mag=|x_q| as 6-bit unsigned (0..32, -32 -> 32);
//    clear the BCD regs. Go to SHIFT at E2.
//  - SHIFT: each cycle, add 3 to any BCD nibble >=5, then shift {bcd,mag} left by 1.
//    Exactly 6 iterations (E3..E8), then go to DONE.
//  - DONE: commit the display regs, led_ovf=snapshot OVF, last=snapshot, valid=1.
//    Go to IDLE at E9.
//  Latency: display regs and led_ovf update exactly 9 edges after E0.
//  busy=1 in LOAD/SHIFT/DONE; it is 1 after E1 and back to 0 after E9.
//  hold is examined only in IDLE. A conversion already in flight completes regardless of hold.
//  Input change during a conversion: that conversion finishes with its snapshot.
//  IDLE then detects the mismatch and reconverts; no glitch or mixed digits appear.
//  Digit map (index 3..0):
//  - 3 = '-' if sign, else blank.
//  - 2 = tens; blank if 0.
//  - 1 = ones; always shown.
//  - 0 = fxn (0..7).
//  Seg codes:
//  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
//  - '-'=3F, blank=7F.
//  Refresh:
//  - Counter runs 0..REFRESH_DIV-1; on wrap, the digit index increments mod 4 (0,1,2,3,0...).
//  - an/seg are registered and change on the same edge, so exactly one anode is low after reset.
//  - Scan is independent of the FSM. Display regs change only at DONE, never mid-scan for a partial value.
// TESTING (REFRESH_DIV=4 in bench)
//  1. rst=1 3 cycles -> an=F, seg=7F, led_ovf=0, busy=0; release, X=0, fxn=0 -> busy=1 after 1 edge;
//     at E9 digits blank,blank,'0','0'.
//  2. X=6'b011111, fxn=6, OVF=0 -> at E9 digits blank,'3','1','6' (seg 7F,30,79,02).
//     an cycles 1110,1101,1011,0111, each held 4 clks.
//  3. X=6'b100000 -> '-','3','2'. X=6'b111101 -> '-',blank,'3'. X=6'b001010 -> blank,'1','0'.
//  4. Shown X=5; hold=1; X=9 -> busy stays 0, display stays 5. Drop hold -> busy next edge, '9' at E9.
//  5. X 5->9 at 3rd SHIFT cycle with OVF=2'b01 -> '5' committed first, then reconversion.
//     Final '9' and led_ovf=01; no other intermediate values.
//  6. rst pulsed mid-SHIFT -> next edge all outputs at reset values and FSM=IDLE;
//     after release a fresh conversion of the current X completes 9 edges later.

Source files
------------

// File: rtl/alu_result_display.sv
// ---------------------------------------------------------------------------
// alu_result_display
//   Display back-end for the 6-bit ALU. The ALU result X (two's complement),
//   its flags and the function select are registered every cycle. When the
//   registered inputs differ from what is on the display, a sequential
//   double-dabble converter turns |X| into two BCD digits. The finished digits
//   and the flags are then committed together. A free-running scanner
//   time-multiplexes the four-digit 7-segment display.
//
//   Ports
//     clk      system clock, rising edge
//     rst      synchronous reset, active-high
//     X        ALU result, two's complement
//     OVF      ALU flags {c_out, overflow}
//     fxn      ALU function select, shown on the rightmost digit
//     hold     1 = do not start new conversions (display frozen)
//     seg      cathodes, active-low, {g,f,e,d,c,b,a}
//     dp       decimal point, active-low, always off
//     an       anodes, active-low, an[0] = rightmost digit
//     led_ovf  flags of the snapshot currently displayed
//     busy     conversion in flight (LOAD/SHIFT/DONE)
//
//   Digit layout (3..0): sign ('-' or blank), tens (blank if 0), ones, fxn.
// ---------------------------------------------------------------------------
module alu_result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] X,
  input  logic [1:0] OVF,
  input  logic [2:0] fxn,
  input  logic       hold,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic [1:0] led_ovf,
  output logic       busy
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  // Everything that defines what the display shows, compared as one word.
  typedef struct packed {
    logic [5:0] x;
    logic [1:0] ovf;
    logic [2:0] fxn;
  } snap_t;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Input sampling
  // -------------------------------------------------------------------------
  snap_t in_q;

  always_ff @(posedge clk) begin
    in_q <= {X, OVF, fxn};
  end

  // -------------------------------------------------------------------------
  // Conversion FSM
  // -------------------------------------------------------------------------
  state_t state, nxt;
  snap_t  snap, last;
  logic   valid;
  logic [2:0] sh_cnt;
  logic   load_en, shift_en, commit_en;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      // valid=0 forces one conversion after reset even if X matches 'last'.
      S_IDLE:  if (!hold && (!valid || in_q != last)) nxt = S_LOAD;
      S_LOAD:  nxt = S_SHIFT;
      S_SHIFT: if (sh_cnt == 3'd5) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    load_en   = (state == S_LOAD);
    shift_en  = (state == S_SHIFT);
    commit_en = (state == S_DONE);
  end

  // -------------------------------------------------------------------------
  // Double-dabble datapath
  // -------------------------------------------------------------------------
  logic       sign;
  logic [5:0] mag, mag_abs;
  logic [7:0] bcd, bcd_adj;

  // -32 negates to itself in 6 bits, which read unsigned is 32 as wanted.
  assign mag_abs = in_q.x[5] ? 6'(-in_q.x) : in_q.x;

  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
  end

  logic [3:0][6:0] disp;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      last    <= '0;
      snap    <= '0;
      sign    <= 1'b0;
      mag     <= '0;
      bcd     <= '0;
      sh_cnt  <= '0;
      disp    <= {4{SEG_BLANK}};
      led_ovf <= '0;
    end else begin
      if (load_en) begin
        snap   <= in_q;
        sign   <= in_q.x[5];
        mag    <= mag_abs;
        bcd    <= '0;
        sh_cnt <= '0;
      end
      if (shift_en) begin
        // Tens never exceeds 3, so the top adjusted bit is always 0.
        {bcd, mag} <= {bcd_adj[6:0], mag, 1'b0};
        sh_cnt     <= sh_cnt + 3'd1;
      end
      if (commit_en) begin
        // Digits and LEDs come from one snapshot and update on one edge.
        disp[3] <= sign ? SEG_DASH : SEG_BLANK;
        disp[2] <= (bcd[7:4] == 4'd0) ? SEG_BLANK : seg_enc(bcd[7:4]);
        disp[1] <= seg_enc(bcd[3:0]);
        disp[0] <= seg_enc({1'b0, snap.fxn});
        led_ovf <= snap.ovf;
        last    <= snap;
        valid   <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Display scan: independent of the converter. an and seg are both
  // registered from the same digit index, so they always switch together.
  // -------------------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      seg <= disp[idx];
      an  <= ~(4'b0001 << idx);
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display. The stimulus side pushes the
// expected display (four segment codes plus LED flags, computed from the
// signed value with plain arithmetic) whenever it gives the DUT a new input
// set; a monitor process pops an entry at every busy 1->0 commit and checks
// each lit digit against the current expectation on every cycle.
module tb_alu_result_display;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] X = '0;
  logic [1:0] OVF = '0;
  logic [2:0] fxn = '0;
  logic       hold = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic [1:0] led_ovf;
  logic       busy;

  alu_result_display #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .X(X), .OVF(OVF), .fxn(fxn), .hold(hold),
    .seg(seg), .dp(dp), .an(an), .led_ovf(led_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] CODE [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct packed {
    logic [3:0][6:0] d;
    logic [1:0]      ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  logic [10:0] last_key;
  logic        last_valid;

  function automatic exp_t model(input logic [5:0] x, input logic [1:0] o,
                                 input logic [2:0] f);
    exp_t e;
    int v, m;
    v = int'($signed(x));
    m = (v < 0) ? -v : v;
    e.d[3] = (v < 0) ? 7'h3F : 7'h7F;
    e.d[2] = (m / 10 == 0) ? 7'h7F : CODE[m / 10];
    e.d[1] = CODE[m % 10];
    e.d[0] = CODE[f];
    e.ovf  = o;
    return e;
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e.d   = {4{7'h7F}};
    e.ovf = 2'b00;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic mon_loop();
    logic pb;
    int   d;
    pb  = 1'b0;
    cur = blank();
    forever begin
      @(negedge clk);
      if (rst) begin
        cur = blank();
        pb  = 1'b0;
      end else begin
        d = -1;
        case (an)
          4'b1110: d = 0;
          4'b1101: d = 1;
          4'b1011: d = 2;
          4'b0111: d = 3;
          4'b1111: d = -1;
          default: begin
            tests++; fails++;
            $display("FAIL an_onehot: got %b, expected one low bit", an);
          end
        endcase
        if (d >= 0) check($sformatf("seg_digit%0d", d), 32'(seg), 32'(cur.d[d]));
        if (pb && !busy) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_commit: got a commit, expected none");
          end else begin
            cur = exp_q.pop_front();
            check("led_ovf", 32'(led_ovf), 32'(cur.ovf));
            check("dp", 32'(dp), 32'd1);
          end
        end
        pb = busy;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive inputs; a commit is expected only when the set differs from the
  // last one that will be shown (or nothing has been shown since reset).
  task automatic apply(input logic [5:0] x, input logic [1:0] o, input logic [2:0] f);
    X = x; OVF = o; fxn = f;
    if (!last_valid || {x, o, f} != last_key) begin
      exp_q.push_back(model(x, o, f));
      last_key   = {x, o, f};
      last_valid = 1'b1;
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      step(1);
      n++;
    end
    check({"drain_", nm}, 32'(exp_q.size() == 0 && !busy), 32'd1);
    step(20);   // let the scanner show every digit of the result
  endtask

  initial begin
    logic [3:0] s [16];
    logic ok, saw_busy;
    logic [5:0] rx, rx2;
    logic [1:0] ro;
    logic [2:0] rf;
    int cnt;

    last_valid = 1'b0;
    last_key   = '0;
    fork
      mon_loop();
    join_none

    // 1. reset values, forced first conversion, 0 displayed
    rst = 1'b1;
    step(3);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_led", 32'(led_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dp", 32'(dp), 32'd1);
    rst = 1'b0;
    apply(6'd0, 2'b00, 3'd0);
    step(1);
    check("busy_after_reset", 32'(busy), 32'd1);
    drain("zero");

    // 2. 31 / fxn 6: latency and anode scan order
    apply(6'b011111, 2'b00, 3'd6);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k == 1)  check("lat_e0_busy", 32'(busy), 32'd0);
      if (k == 2)  check("lat_e1_busy", 32'(busy), 32'd1);
      if (k == 9)  check("lat_e8_busy", 32'(busy), 32'd1);
      if (k == 10) check("lat_e9_busy", 32'(busy), 32'd0);
    end
    drain("x31");
    for (int i = 0; i < 16; i++) begin
      s[i] = an;
      step(1);
    end
    ok = 1'b1;
    for (int i = 1; i < 16; i++)
      if (s[i] != s[i-1] && s[i] != {s[i-1][2:0], s[i-1][3]}) ok = 1'b0;
    for (int p = 0; p < 4; p++) begin
      cnt = 0;
      for (int i = 0; i < 16; i++) if (s[i] == ~(4'b0001 << p)) cnt++;
      if (cnt != 4) ok = 1'b0;
    end
    check("an_scan_order", 32'(ok), 32'd1);

    // 3. boundary values
    apply(6'b100000, 2'b10, 3'd1); drain("m32");
    apply(6'b111101, 2'b00, 3'd2); drain("m3");
    apply(6'b001010, 2'b11, 3'd3); drain("p10");

    // 4. hold freezes the display
    apply(6'd5, 2'b00, 3'd4); drain("five");
    hold = 1'b1;
    apply(6'd9, 2'b00, 3'd4);
    saw_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (busy) saw_busy = 1'b1;
    end
    check("hold_no_busy", 32'(saw_busy), 32'd0);
    check("hold_pending", 32'(exp_q.size()), 32'd1);
    hold = 1'b0;
    step(1);
    check("unhold_busy", 32'(busy), 32'd1);
    drain("nine");

    // 5. input change mid-conversion: 5 commits, then 9
    apply(6'd5, 2'b01, 3'd4);
    step(5);
    apply(6'd9, 2'b01, 3'd4);
    drain("midchange");
    check("midchange_led", 32'(led_ovf), 32'b01);

    // 6. reset in the middle of SHIFT
    apply(6'b110000, 2'b10, 3'd7);
    step(5);
    rst = 1'b1;
    step(1);
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_led", 32'(led_ovf), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    last_valid = 1'b0;
    rst = 1'b0;
    apply(6'b110000, 2'b10, 3'd7);
    step(1);
    check("midrst_restart", 32'(busy), 32'd1);
    drain("after_midrst");

    // random stimulus, some with a second change during the conversion
    for (int it = 0; it < 40; it++) begin
      rx = 6'($urandom); ro = 2'($urandom); rf = 3'($urandom);
      apply(rx, ro, rf);
      if ($urandom_range(0, 3) == 0) begin
        step($urandom_range(4, 8));
        rx2 = rx ^ 6'($urandom_range(1, 63));
        apply(rx2, ro, rf);
      end
      drain("rand");
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
